// File: rtl/pc_fetch_unit.sv
// PC register and two-clock fetch sequencer feeding the instruction memory and the PC half of IF/ID.
// Latency: address-to-record 2 clocks; a redirect loads its target at the next fetch boundary.
// Backpressure: stall holds PC and the IF/ID record, but only at fetch boundaries; redirects beat stall.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [15:0] ex_target,
  input  logic        id_redirect,
  input  logic [15:0] id_target,
  output logic [15:0] address,
  output logic        phase,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus1,
  output logic        if_valid
);

  // Source tag of the pending redirect; EX outranks ID.
  localparam logic SRC_ID = 1'b0;
  localparam logic SRC_EX = 1'b1;

  logic        phase_q;
  logic [15:0] pc_q;
  logic [15:0] pc_inc;

  logic        pend_v;
  logic        pend_src;
  logic [15:0] pend_tgt;

  // Pending entry merged with this clock's requests.
  logic        redir_v;
  logic        redir_src;
  logic [15:0] redir_tgt;

  logic        boundary;

  logic [15:0] if_pc_q;
  logic [15:0] if_pc_plus1_q;
  logic        if_valid_q;

  // The edge that ends the data phase is the only one allowed to move the PC.
  assign boundary = phase_q;
  assign pc_inc   = pc_q + 16'd1;

  // Merge new redirect requests into the pending entry: EX always overwrites,
  // ID only lands when no EX redirect is already waiting.
  always_comb begin
    redir_v   = pend_v;
    redir_src = pend_src;
    redir_tgt = pend_tgt;
    if (ex_redirect) begin
      redir_v   = 1'b1;
      redir_src = SRC_EX;
      redir_tgt = ex_target;
    end else if (id_redirect && !(pend_v && (pend_src == SRC_EX))) begin
      redir_v   = 1'b1;
      redir_src = SRC_ID;
      redir_tgt = id_target;
    end
  end

  // Phase toggles every clock, mirroring the memory's address/data phases.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
    end
  end

  // Pending redirect accumulates within a fetch cycle and is consumed at the boundary.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pend_v   <= 1'b0;
      pend_src <= SRC_ID;
      pend_tgt <= 16'h0000;
    end else if (boundary) begin
      pend_v   <= 1'b0;
      pend_src <= SRC_ID;
      pend_tgt <= 16'h0000;
    end else begin
      pend_v   <= redir_v;
      pend_src <= redir_src;
      pend_tgt <= redir_tgt;
    end
  end

  // Boundary action: redirect squashes the in-flight fetch, else stall holds, else advance.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q          <= RESET_PC;
      if_pc_q       <= 16'h0000;
      if_pc_plus1_q <= 16'h0000;
      if_valid_q    <= 1'b0;
    end else if (boundary) begin
      if (redir_v) begin
        // Even a redirect to the current PC squashes and refetches.
        pc_q       <= redir_tgt;
        if_valid_q <= 1'b0;
      end else if (!stall) begin
        if_pc_q       <= pc_q;
        if_pc_plus1_q <= pc_inc;
        if_valid_q    <= 1'b1;
        pc_q          <= pc_inc;
      end
    end
  end

  assign address     = pc_q;
  assign phase       = phase_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus1 = if_pc_plus1_q;
  assign if_valid    = if_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic.
// Reference model tracks per-fetch-cycle redirect requests rather than a pending register.
// All outputs are checked 1 ns after every rising edge.
module tb_pc_fetch_unit;

  localparam logic [15:0] RPC = 16'h0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        stall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [15:0] ex_target = 16'h0000;
  logic        id_redirect = 1'b0;
  logic [15:0] id_target = 16'h0000;
  logic [15:0] address;
  logic        phase;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus1;
  logic        if_valid;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: which redirects were requested in the current fetch cycle.
  logic [15:0] m_pc, m_ifpc, m_ifp1;
  logic        m_ph, m_ifv;
  logic        saw_ex, saw_id;
  logic [15:0] last_ex, last_id;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .CLK(CLK), .RST(RST), .stall(stall),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .id_redirect(id_redirect), .id_target(id_target),
    .address(address), .phase(phase), .if_pc(if_pc),
    .if_pc_plus1(if_pc_plus1), .if_valid(if_valid)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fetch cycle semantics: the last EX target in a cycle wins; otherwise the last ID target.
  task automatic model_edge();
    if (!RST) begin
      m_pc = RPC; m_ph = 1'b0; m_ifpc = 16'h0; m_ifp1 = 16'h0; m_ifv = 1'b0;
      saw_ex = 1'b0; saw_id = 1'b0;
    end else begin
      if (ex_redirect) begin saw_ex = 1'b1; last_ex = ex_target; end
      if (id_redirect) begin saw_id = 1'b1; last_id = id_target; end
      if (m_ph) begin
        if (saw_ex || saw_id) begin
          m_pc  = saw_ex ? last_ex : last_id;
          m_ifv = 1'b0;
        end else if (!stall) begin
          m_ifpc = m_pc;
          m_ifp1 = m_pc + 16'd1;
          m_ifv  = 1'b1;
          m_pc   = m_pc + 16'd1;
        end
        saw_ex = 1'b0; saw_id = 1'b0;
      end
      m_ph = ~m_ph;
    end
  endtask

  task automatic step(input logic rst_n, input logic s, input logic ex, input logic [15:0] et,
                      input logic id, input logic [15:0] it);
    RST = rst_n; stall = s; ex_redirect = ex; ex_target = et; id_redirect = id; id_target = it;
    @(posedge CLK);
    model_edge();
    #1;
    chk("address", address, m_pc);
    chk("phase", {15'h0, phase}, {15'h0, m_ph});
    chk("if_pc", if_pc, m_ifpc);
    chk("if_pc_plus1", if_pc_plus1, m_ifp1);
    chk("if_valid", {15'h0, if_valid}, {15'h0, m_ifv});
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    saw_ex = 1'b0; saw_id = 1'b0; last_ex = 16'h0; last_id = 16'h0;
    m_pc = RPC; m_ph = 1'b0; m_ifpc = 16'h0; m_ifp1 = 16'h0; m_ifv = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("rst_address", address, 16'h0000);
    chk("rst_valid", {15'h0, if_valid}, 16'h0);
    chk("rst_phase", {15'h0, phase}, 16'h0);

    // Free run 6 clocks from release
    free(1);
    chk("edge1_address", address, 16'h0000);
    chk("edge1_phase", {15'h0, phase}, 16'h1);
    free(1);
    chk("edge2_if_pc", if_pc, 16'h0000);
    chk("edge2_valid", {15'h0, if_valid}, 16'h1);
    chk("edge2_address", address, 16'h0001);
    free(4);
    chk("edge6_if_pc", if_pc, 16'h0002);
    chk("edge6_address", address, 16'h0003);

    // Advance to PC=5 in phase 0, then stall at two boundaries
    free(4);
    chk("pc5_address", address, 16'h0005);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("stall_address", address, 16'h0005);
    chk("stall_if_pc", if_pc, 16'h0004);
    chk("stall_valid", {15'h0, if_valid}, 16'h1);
    // Stall pulsed only in phase 0 has no effect
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("ph0stall_address", address, 16'h0006);
    chk("ph0stall_if_pc", if_pc, 16'h0005);

    // ID redirect in phase 0 with PC=7
    free(2);
    chk("pc7_address", address, 16'h0007);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0040);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("idred_address", address, 16'h0040);
    chk("idred_valid", {15'h0, if_valid}, 16'h0);
    free(2);
    chk("idred_if_pc", if_pc, 16'h0040);
    chk("idred_valid2", {15'h0, if_valid}, 16'h1);

    // EX/ID priority cases
    step(1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("same_clk_ex_wins", address, 16'h0100);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0200);
    step(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0);
    chk("id_then_ex", address, 16'h0100);
    step(1'b1, 1'b0, 1'b1, 16'h0300, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0200);
    chk("ex_then_id", address, 16'h0300);

    // Wrap at 16'hFFFF
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("wrap_pre_address", address, 16'hFFFF);
    free(2);
    chk("wrap_if_pc", if_pc, 16'hFFFF);
    chk("wrap_if_pc_plus1", if_pc_plus1, 16'h0000);
    chk("wrap_address", address, 16'h0000);

    // Redirect beats stall at the same boundary
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("redir_stall_address", address, 16'h1234);
    chk("redir_stall_valid", {15'h0, if_valid}, 16'h0);

    // Redirect to the current PC squashes and refetches
    step(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("self_redir_address", address, 16'h1234);
    chk("self_redir_valid", {15'h0, if_valid}, 16'h0);
    free(2);
    chk("self_redir_if_pc", if_pc, 16'h1234);

    // Reset in phase 1 with a pending redirect
    step(1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 16'h6666, 1'b0, 16'h0);
    chk("midrst_address", address, RPC);
    chk("midrst_valid", {15'h0, if_valid}, 16'h0);
    chk("midrst_phase", {15'h0, phase}, 16'h0);
    free(2);
    chk("midrst_if_pc", if_pc, RPC);
    chk("midrst_address2", address, RPC + 16'd1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, ex, id;
      logic [15:0] et, it;
      r  = ($urandom_range(0, 199) != 0);
      s  = ($urandom_range(0, 1) == 1);
      ex = ($urandom_range(0, 7) == 0);
      id = ($urandom_range(0, 7) == 0);
      et = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      it = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      step(r, s, ex, et, id, it);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
